// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_i2s_tx
// Description : I2S transmitter for a stereo DAC codec. It accepts one
//               left/right frame into a one-entry holding buffer through a
//               valid/ready handshake. It generates BCLK by dividing the
//               system clock, drives LRCK (0 = left, 1 = right), and shifts
//               each sample out MSB first, one BCLK after the LRCK edge.
//               If no frame is held at a frame start, the block pulses
//               underrun and sends the underrun frame.
// Ports       : clock        system clock, all logic on posedge
//               clear        synchronous active-high reset
//               left_in      left channel sample (two's complement)
//               right_in     right channel sample (two's complement)
//               valid        left_in/right_in carry a frame to transfer
//               ready        registered, holding buffer empty
//               aud_bclk     bit clock to the codec
//               aud_daclrck  word select, 0 = left slot, 1 = right slot
//               aud_dacdat   serial data, MSB first
//               underrun     one-cycle pulse, frame start with empty buffer
// Config      : AUDIO_I2S_TX_REPEAT_EN - if defined, the underrun frame is
//               the last frame loaded (0 if none since reset). If undefined,
//               the underrun frame is mute (all zeros).
// Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int SAMPLE_W  = 24,
    parameter int SLOT_W    = 32,
    parameter int BCLK_HALF = 9
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                valid,
    output logic                ready,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic                underrun
);

    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int DIV_W = $clog2(BCLK_HALF);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] C_SLOT    = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] C_SAMP    = CNT_W'(SAMPLE_W);
    localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0]    r_div;
    logic                r_bclk;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_lrck;
    logic                r_dat;
    logic                r_ready;
    logic                r_ur;
    logic [SAMPLE_W-1:0] r_hold_l;
    logic [SAMPLE_W-1:0] r_hold_r;
    logic [SAMPLE_W-1:0] r_sh_l;
    logic [SAMPLE_W-1:0] r_sh_r;

    logic                w_fall;
    logic                w_frame_start;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_right;
    logic [CNT_W-1:0]    w_k;
    logic                w_data_bit;
    logic [SAMPLE_W-1:0] w_ur_l;
    logic [SAMPLE_W-1:0] w_ur_r;

    // A fall event happens when the divider reaches terminal count while
    // BCLK is high. All serial outputs change only on that cycle, so the
    // codec samples stable data on the BCLK rising edge.
    assign w_fall        = (r_div == C_DIV_MAX) && r_bclk;
    assign w_frame_start = w_fall && (r_cnt == C_CNT_MAX);
    assign w_cnt_nxt     = (r_cnt == C_CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
    assign w_right       = (w_cnt_nxt >= C_SLOT);
    assign w_k           = w_right ? (w_cnt_nxt - C_SLOT) : w_cnt_nxt;
    // Slot index 0 is the one-BCLK I2S delay. Indices past the sample are
    // zero padding.
    assign w_data_bit    = (w_k != '0) && (w_k <= C_SAMP);

`ifdef AUDIO_I2S_TX_REPEAT_EN
    logic [SAMPLE_W-1:0] r_last_l;
    logic [SAMPLE_W-1:0] r_last_r;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_frame_start && !r_ready) begin
            r_last_l <= r_hold_l;
            r_last_r <= r_hold_r;
        end
    end

    assign w_ur_l = r_last_l;
    assign w_ur_r = r_last_r;
`else
    assign w_ur_l = '0;
    assign w_ur_r = '0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            r_div    <= '0;
            r_bclk   <= 1'b0;
            r_cnt    <= C_CNT_MAX;
            r_lrck   <= 1'b0;
            r_dat    <= 1'b0;
            r_ready  <= 1'b1;
            r_ur     <= 1'b0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_sh_l   <= '0;
            r_sh_r   <= '0;
        end else begin
            r_ur <= 1'b0;

            if (r_div == C_DIV_MAX) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            if (w_fall) begin
                r_cnt  <= w_cnt_nxt;
                r_lrck <= w_right;
                if (w_data_bit) begin
                    if (w_right) begin
                        r_dat  <= r_sh_r[SAMPLE_W-1];
                        r_sh_r <= {r_sh_r[SAMPLE_W-2:0], 1'b0};
                    end else begin
                        r_dat  <= r_sh_l[SAMPLE_W-1];
                        r_sh_l <= {r_sh_l[SAMPLE_W-2:0], 1'b0};
                    end
                end else begin
                    r_dat <= 1'b0;
                end
            end

            // Slot index is 0 at frame start, so no shift happens on that
            // cycle. The loads below have nothing to collide with.
            if (w_frame_start) begin
                if (!r_ready) begin
                    r_sh_l  <= r_hold_l;
                    r_sh_r  <= r_hold_r;
                    r_ready <= 1'b1;
                end else begin
                    // The buffer was empty at the frame start. A frame
                    // accepted on this cycle waits for the next frame start.
                    r_ur   <= 1'b1;
                    r_sh_l <= w_ur_l;
                    r_sh_r <= w_ur_r;
                    if (valid) begin
                        r_hold_l <= left_in;
                        r_hold_r <= right_in;
                        r_ready  <= 1'b0;
                    end
                end
            end else if (valid && r_ready) begin
                r_hold_l <= left_in;
                r_hold_r <= right_in;
                r_ready  <= 1'b0;
            end
        end
    end

    assign ready       = r_ready;
    assign aud_bclk    = r_bclk;
    assign aud_daclrck = r_lrck;
    assign aud_dacdat  = r_dat;
    assign underrun    = r_ur;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_i2s_tx
// Description : Self-checking bench for audio_i2s_tx (default parameters).
//               Directed stimulus queues the hand-computed serial image of
//               every frame. A monitor rebuilds each 64-bit frame from
//               aud_dacdat on BCLK fall events and compares it with the
//               queue head, together with the underrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

    localparam logic [23:0] c_al  = 24'hA5F00F;
    localparam logic [23:0] c_ar  = 24'h123456;
    localparam logic [23:0] c_f2l = 24'h0F0F0F;
    localparam logic [23:0] c_f2r = 24'hF0F0F0;
    localparam logic [23:0] c_f3l = 24'h000001;
    localparam logic [23:0] c_f3r = 24'hFFFFFE;
    localparam logic [23:0] c_f4l = 24'h7FFFFF;
    localparam logic [23:0] c_f4r = 24'h800000;
    localparam logic [23:0] c_f5l = 24'h5A5A5A;
    localparam logic [23:0] c_f5r = 24'hC3C3C3;
    localparam logic [23:0] c_f6l = 24'h111111;
    localparam logic [23:0] c_f6r = 24'h222222;
`ifdef AUDIO_I2S_TX_REPEAT_EN
    localparam logic [23:0] c_repl = c_f4l;
    localparam logic [23:0] c_repr = c_f4r;
`else
    localparam logic [23:0] c_repl = 24'h0;
    localparam logic [23:0] c_repr = 24'h0;
`endif

    logic        clk = 1'b0;
    logic        clear;
    logic [23:0] left_in;
    logic [23:0] right_in;
    logic        valid;
    logic        ready;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] exp_q[$];

    always #10 clk = ~clk;

    audio_i2s_tx #(
        .SAMPLE_W (24),
        .SLOT_W   (32),
        .BCLK_HALF(9)
    ) dut (
        .clock      (clk),
        .clear      (clear),
        .left_in    (left_in),
        .right_in   (right_in),
        .valid      (valid),
        .ready      (ready),
        .aud_bclk   (aud_bclk),
        .aud_daclrck(aud_daclrck),
        .aud_dacdat (aud_dacdat),
        .underrun   (underrun)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Serial image of one frame in transmit order (first bit at the MSB),
    // with the underrun flag for that frame start on top.
    function automatic logic [64:0] mk(input logic ur, input logic [23:0] l, input logic [23:0] r);
        return {ur, 1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [5:0]  m_cnt;
    logic [63:0] m_acc;
    logic        m_prev;
    logic        m_ur_fs;
    logic        m_fall;
    logic [64:0] m_want;
    int          ur_total = 0;

    always @(negedge clk) begin
        if (clear) begin
            m_cnt   = 6'd63;
            m_acc   = '0;
            m_prev  = 1'b0;
            m_ur_fs = 1'b0;
        end else begin
            m_fall = m_prev && !aud_bclk;
            if (m_fall) begin
                m_cnt = m_cnt + 6'd1;
                check("lrck", 65'(aud_daclrck), 65'(m_cnt >= 6'd32));
                m_acc = {m_acc[62:0], aud_dacdat};
                if (m_cnt == 6'd0) m_ur_fs = underrun;
            end
            if (underrun) begin
                ur_total++;
                if (!(m_fall && m_cnt == 6'd0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL underrun_timing: pulse seen off frame start at slot bit %0d", m_cnt);
                end
            end
            if (m_fall && m_cnt == 6'd63) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame: got %h, expected nothing queued", {m_ur_fs, m_acc});
                end else begin
                    m_want = exp_q.pop_front();
                    check("frame", {m_ur_fs, m_acc}, m_want);
                end
            end
            m_prev = aud_bclk;
        end
    end

    // ---------------- stimulus ----------------
    int cyc;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        int   rise_c, fall1_c, fall65_c, lr_c, nfall, ready_hi;
        logic prev_b;

        clear    = 1'b1;
        valid    = 1'b0;
        left_in  = '0;
        right_in = '0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_ready", 65'(ready), 65'(1));
        check("rst_bclk", 65'(aud_bclk), 65'(0));
        check("rst_lrck", 65'(aud_daclrck), 65'(0));
        check("rst_dat", 65'(aud_dacdat), 65'(0));
        check("rst_underrun", 65'(underrun), 65'(0));

        // Release, with frame A offered before the first frame start.
        clear    = 1'b0;
        cyc      = 0;
        valid    = 1'b1;
        left_in  = c_al;
        right_in = c_ar;
        exp_q.push_back(mk(1'b0, c_al, c_ar));

        rise_c = -1; fall1_c = -1; fall65_c = -1; lr_c = -1;
        nfall = 0; ready_hi = 0; prev_b = 1'b0;
        for (int c = 1; c <= 1171; c++) begin
            step();
            if (aud_bclk && rise_c < 0) rise_c = c;
            if (prev_b && !aud_bclk) begin
                nfall++;
                if (nfall == 1)  fall1_c  = c;
                if (nfall == 65) fall65_c = c;
            end
            prev_b = aud_bclk;
            if (aud_daclrck && lr_c < 0) lr_c = c;
            if (c >= 20 && c <= 1169 && ready) ready_hi++;
            if (c == 1) begin
                check("accept_A_ready", 65'(ready), 65'(0));
                valid = 1'b0;
            end
            if (c == 17) begin
                check("ready_before_fs0", 65'(ready), 65'(0));
                valid    = 1'b1;
                left_in  = c_f2l;
                right_in = c_f2r;
            end
            if (c == 18) check("ready_after_fs0", 65'(ready), 65'(1));
            if (c == 19) begin
                check("accept_F2_ready", 65'(ready), 65'(0));
                exp_q.push_back(mk(1'b0, c_f2l, c_f2r));
                left_in  = c_f3l;
                right_in = c_f3r;
            end
            if (c == 1170) check("ready_after_fs1", 65'(ready), 65'(1));
            if (c == 1171) begin
                check("accept_F3_ready", 65'(ready), 65'(0));
                exp_q.push_back(mk(1'b0, c_f3l, c_f3r));
                left_in  = c_f4l;
                right_in = c_f4r;
            end
        end
        check("bclk_rise_cycle", 65'(rise_c), 65'(9));
        check("bclk_fall_cycle", 65'(fall1_c), 65'(18));
        check("lrck_rise_cycle", 65'(lr_c), 65'(594));
        check("frame_period", 65'(fall65_c - fall1_c), 65'(1152));
        check("no_extra_accept", 65'(ready_hi), 65'(0));

        goto(2322);
        check("ready_after_fs2", 65'(ready), 65'(1));
        goto(2323);
        check("accept_F4_ready", 65'(ready), 65'(0));
        exp_q.push_back(mk(1'b0, c_f4l, c_f4r));
        valid = 1'b0;
        exp_q.push_back(mk(1'b1, c_repl, c_repr));   // fs4
        exp_q.push_back(mk(1'b1, c_repl, c_repr));   // fs5

        // Accept lands on the frame-start edge of fs6 (cycle 6930).
        goto(6929);
        check("ready_before_fs6", 65'(ready), 65'(1));
        valid    = 1'b1;
        left_in  = c_f5l;
        right_in = c_f5r;
        goto(6930);
        check("fs6_underrun", 65'(underrun), 65'(1));
        check("fs6_accept_ready", 65'(ready), 65'(0));
        valid = 1'b0;
        exp_q.push_back(mk(1'b1, c_repl, c_repr));   // fs6
        exp_q.push_back(mk(1'b0, c_f5l, c_f5r));     // fs7, aborted below

        goto(8082);
        check("ready_after_fs7", 65'(ready), 65'(1));
        goto(8084);
        valid    = 1'b1;
        left_in  = c_f6l;
        right_in = c_f6r;
        goto(8085);
        check("accept_F6_ready", 65'(ready), 65'(0));
        valid = 1'b0;

        // bit_cnt reaches 40 on the fall event at cycle 8802.
        goto(8802);
        check("mid_lrck", 65'(aud_daclrck), 65'(1));
        check("mid_dat", 65'(aud_dacdat), 65'(1));
        clear = 1'b1;
        exp_q.delete();
        goto(8803);
        check("clr_ready", 65'(ready), 65'(1));
        check("clr_bclk", 65'(aud_bclk), 65'(0));
        check("clr_lrck", 65'(aud_daclrck), 65'(0));
        check("clr_dat", 65'(aud_dacdat), 65'(0));
        check("clr_underrun", 65'(underrun), 65'(0));
        clear = 1'b0;
        cyc   = 0;
        // F6 was discarded and the last-frame register was cleared, so
        // this frame is a mute underrun in both builds.
        exp_q.push_back(mk(1'b1, 24'h0, 24'h0));

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 65'(exp_q.size()), 65'(0));
        check("underrun_total", 65'(ur_total), 65'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
